// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: ID-stage hazard inputs and stall/flush/forward outputs of the pipeline controller
interface pipeline_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_re;
  logic        id_rs2_re;
  logic [4:0]  id_rd;
  logic        id_rd_we;
  logic        id_mem_re;
  logic        id_mem_we;
  logic        branch_taken;
  logic        dmem_ready;
  logic        stall_if;
  logic        stall_id;
  logic        stall_ex;
  logic        stall_mem;
  logic        flush_id;
  logic        flush_ex;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_re, id_rs2_re, id_rd, id_rd_we,
           id_mem_re, id_mem_we, branch_taken, dmem_ready,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_re, id_rs2_re, id_rd, id_rd_we,
           id_mem_re, id_mem_we, branch_taken, dmem_ready,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage hazard unit with load-use stall, branch flush, memory wait, forwarding and perf counters
module pipeline_ctrl (
  input logic           clk,
  input logic           rst,
  pipeline_ctrl_if.slave p
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mem;
  } shadow_t;
  state_t         state_q, state_d;
  shadow_t [2:0]  sh_q, sh_d;
  logic [1:0]     fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [31:0]    stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic           ex_a, ex_b, mem_a, mem_b, mem_wait, br, lu, adv;
  shadow_t        id_sh;
  function automatic logic hit(input logic [4:0] s, input logic re, input shadow_t x);
    return re && s != 5'd0 && x.v && x.we && x.rd == s;
  endfunction
  // sh_q[0]=EX, sh_q[1]=MEM, sh_q[2]=WB
  always_comb begin
    ex_a        = hit(p.id_rs1, p.id_rs1_re, sh_q[0]);
    ex_b        = hit(p.id_rs2, p.id_rs2_re, sh_q[0]);
    mem_a       = hit(p.id_rs1, p.id_rs1_re, sh_q[1]);
    mem_b       = hit(p.id_rs2, p.id_rs2_re, sh_q[1]);
    mem_wait    = !p.dmem_ready && (state_q == MEM_WAIT || (sh_q[1].v && sh_q[1].mem));
    br          = !mem_wait && p.branch_taken;
    lu          = !mem_wait && !p.branch_taken && p.id_valid && sh_q[0].ld && (ex_a || ex_b);
    adv         = !mem_wait && !br && !lu;
    p.stall_if  = !rst && (mem_wait || lu);
    p.stall_id  = !rst && (mem_wait || lu);
    p.stall_ex  = !rst && mem_wait;
    p.stall_mem = !rst && mem_wait;
    p.flush_id  = !rst && br;
    p.flush_ex  = !rst && (br || lu);
    id_sh       = adv ? shadow_t'{p.id_valid, p.id_rd, p.id_rd_we, p.id_mem_re,
                                  p.id_mem_re || p.id_mem_we} : shadow_t'('0);
    state_d     = rst ? RUN : mem_wait ? MEM_WAIT : RUN;
    sh_d        = rst ? '0 : mem_wait ? sh_q : {sh_q[1], sh_q[0], id_sh};
    fwd_a_d     = rst ? 2'b00 : mem_wait ? fwd_a_q : !adv ? 2'b00 :
                  (ex_a && !sh_q[0].ld) ? 2'b01 : mem_a ? 2'b10 : 2'b00;
    fwd_b_d     = rst ? 2'b00 : mem_wait ? fwd_b_q : !adv ? 2'b00 :
                  (ex_b && !sh_q[0].ld) ? 2'b01 : mem_b ? 2'b10 : 2'b00;
    stall_cnt_d = rst ? '0 : stall_cnt_q + {31'd0, p.stall_if};
    flush_cnt_d = rst ? '0 : flush_cnt_q + {31'd0, p.flush_id};
  end
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    sh_q        <= sh_d;
    fwd_a_q     <= fwd_a_d;
    fwd_b_q     <= fwd_b_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end
  assign p.fwd_a     = fwd_a_q;
  assign p.fwd_b     = fwd_b_q;
  assign p.stall_cnt = stall_cnt_q;
  assign p.flush_cnt = flush_cnt_q;
endmodule
